// File: rtl/data_memory_unit.sv
// ============================================================================
// Module   : data_memory_unit
// Purpose  : M-stage data memory with byte-lane stores, GPIO and cycle-counter
//            MMIO registers, sticky misaligned-store capture, 1-cycle reads.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module data_memory_unit #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic        MemWriteM,
   input  logic [1:0]  ByteAccessM,
   output logic [31:0] ReadData,
   output logic [31:0] GpioOut,
   output logic        MisalignErr,
   output logic [31:0] ErrAddr
);

   localparam int          c_AW         = $clog2(DEPTH_WORDS);
   localparam logic [32:0] c_RAM_BYTES  = 33'(DEPTH_WORDS) << 2;
   localparam logic [31:0] c_CYCLE_ADDR = MMIO_BASE + 32'd4;

   localparam logic [1:0]  c_SIZE_WORD  = 2'b00;
   localparam logic [1:0]  c_SIZE_HALF  = 2'b01;
   localparam logic [1:0]  c_SIZE_BYTE  = 2'b10;

   logic [31:0]     r_mem [DEPTH_WORDS];
   logic [31:0]     r_rd;
   logic [31:0]     r_gpio;
   logic            r_err;
   logic [31:0]     r_err_addr;
   logic [31:0]     r_cycle;

   logic            w_is_ram;
   logic            w_is_gpio;
   logic            w_is_cycle;
   logic [c_AW-1:0] w_idx;
   logic            w_misalign;
   logic [3:0]      w_be;
   logic [31:0]     w_wdata;
   logic            w_store_ok;
   logic            w_ram_we;
   logic            w_gpio_we;
   logic [31:0]     w_ram_merged;
   logic [31:0]     w_gpio_merged;
   logic [31:0]     w_rd_next;

   // Replace only the enabled byte lanes of the old word with the new data.
   function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
      logic [31:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
      end
      return res;
   endfunction

   assign w_is_ram   = ({1'b0, ALUResultM} < c_RAM_BYTES);
   assign w_is_gpio  = (ALUResultM[31:2] == MMIO_BASE[31:2]);
   assign w_is_cycle = (ALUResultM[31:2] == c_CYCLE_ADDR[31:2]);
   assign w_idx      = ALUResultM[c_AW+1:2];

   always_comb begin
      w_misalign = 1'b0;
      w_be       = 4'b1111;
      w_wdata    = WriteDataM;
      case (ByteAccessM)
         c_SIZE_HALF: begin
            w_misalign = ALUResultM[0];
            w_be       = 4'b0011 << ALUResultM[1:0];
            w_wdata    = {2{WriteDataM[15:0]}};
         end
         c_SIZE_BYTE: begin
            w_be       = 4'b0001 << ALUResultM[1:0];
            w_wdata    = {4{WriteDataM[7:0]}};
         end
         default: begin
            w_misalign = (ALUResultM[1:0] != 2'b00);
         end
      endcase
   end

   assign w_store_ok    = MemWriteM && !w_misalign;
   assign w_ram_we      = w_store_ok && w_is_ram;
   assign w_gpio_we     = w_store_ok && w_is_gpio;
   assign w_ram_merged  = w_ram_we  ? f_merge(r_mem[w_idx], w_wdata, w_be) : r_mem[w_idx];
   assign w_gpio_merged = w_gpio_we ? f_merge(r_gpio, w_wdata, w_be)        : r_gpio;

   // Read path returns the post-store word so a same-cycle load sees the write.
   always_comb begin
      w_rd_next = 32'h0;
      if (w_is_ram)        w_rd_next = w_ram_merged;
      else if (w_is_gpio)  w_rd_next = w_gpio_merged;
      else if (w_is_cycle) w_rd_next = r_cycle;
   end

   // RAM has no reset so contents survive it; reset only blocks the store.
   always_ff @(posedge clk) begin
      if (!reset && w_ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd       <= 32'h0;
         r_gpio     <= 32'h0;
         r_err      <= 1'b0;
         r_err_addr <= 32'h0;
         r_cycle    <= 32'h0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         r_rd    <= w_rd_next;
         if (w_gpio_we) r_gpio <= w_gpio_merged;
         if (MemWriteM && w_misalign) begin
            if (!r_err) r_err_addr <= ALUResultM;
            r_err <= 1'b1;
         end
      end
   end

   assign ReadData    = r_rd;
   assign GpioOut     = r_gpio;
   assign MisalignErr = r_err;
   assign ErrAddr     = r_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_unit.sv
// ============================================================================
// Module   : tb_data_memory_unit
// Purpose  : Directed bench for data_memory_unit with a byte-level memory model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_memory_unit;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] MMIO  = 32'hFFFF_0000;
   localparam logic [31:0] CYC   = 32'hFFFF_0004;
   localparam logic [1:0]  SZ_W  = 2'b00;
   localparam logic [1:0]  SZ_H  = 2'b01;
   localparam logic [1:0]  SZ_B  = 2'b10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ALUResultM = 32'h0;
   logic [31:0] WriteDataM = 32'h0;
   logic        MemWriteM = 1'b0;
   logic [1:0]  ByteAccessM = 2'b00;
   logic [31:0] ReadData;
   logic [31:0] GpioOut;
   logic        MisalignErr;
   logic [31:0] ErrAddr;

   int checks = 0;
   int errors = 0;

   data_memory_unit #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MMIO)) dut (
      .clk(clk), .reset(reset), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .MemWriteM(MemWriteM), .ByteAccessM(ByteAccessM), .ReadData(ReadData),
      .GpioOut(GpioOut), .MisalignErr(MisalignErr), .ErrAddr(ErrAddr)
   );

   always #5 clk = ~clk;

   // Behavioural model: byte-addressed RAM with known-flags, registers as plain values.
   logic [7:0]  m_mem [DEPTH*4];
   bit          m_kn  [DEPTH*4];
   logic [31:0] m_rd;
   bit          m_rd_known;
   logic [31:0] m_gpio;
   logic        m_err;
   logic [31:0] m_erraddr;
   logic [31:0] m_edges;
   logic [31:0] m_adj = 32'h0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_rd       <= 32'h0;
         m_rd_known <= 1'b1;
         m_gpio     <= 32'h0;
         m_err      <= 1'b0;
         m_erraddr  <= 32'h0;
         m_edges    <= 32'h0;
      end else begin
         logic [31:0] a;
         bit          mis, is_ram, is_gpio, is_cyc, wr;
         bit [3:0]    en;
         logic [7:0]  nb [4];
         logic [31:0] word;
         bit          known;
         int          base, lane;
         a    = ALUResultM;
         lane = int'(a[1:0]);
         base = int'({a[31:2], 2'b00});
         en   = 4'b0;
         for (int b = 0; b < 4; b++) nb[b] = 8'h0;
         if (ByteAccessM == SZ_H) begin
            mis = (a[0] == 1'b1);
            en[lane] = 1'b1;
            en[(lane + 1) % 4] = 1'b1;
            nb[lane] = WriteDataM[7:0];
            nb[(lane + 1) % 4] = WriteDataM[15:8];
         end else if (ByteAccessM == SZ_B) begin
            mis = 1'b0;
            en[lane] = 1'b1;
            nb[lane] = WriteDataM[7:0];
         end else begin
            mis = (lane != 0);
            en  = 4'b1111;
            for (int b = 0; b < 4; b++) nb[b] = WriteDataM[8*b +: 8];
         end
         is_ram  = (64'(a) < 64'(DEPTH) * 4);
         is_gpio = (a / 4 == MMIO / 4);
         is_cyc  = (a / 4 == CYC / 4);
         wr      = MemWriteM && !mis;
         word    = 32'h0;
         known   = 1'b1;
         if (is_ram) begin
            for (int b = 0; b < 4; b++) begin
               if (wr && en[b]) begin
                  word[8*b +: 8] = nb[b];
                  m_mem[base + b] <= nb[b];
                  m_kn[base + b]  <= 1'b1;
               end else begin
                  word[8*b +: 8] = m_mem[base + b];
                  if (!m_kn[base + b]) known = 1'b0;
               end
            end
         end else if (is_gpio) begin
            for (int b = 0; b < 4; b++)
               word[8*b +: 8] = (wr && en[b]) ? nb[b] : m_gpio[8*b +: 8];
            m_gpio <= word;
         end else if (is_cyc) begin
            word = m_edges + m_adj;
         end
         m_rd       <= word;
         m_rd_known <= known;
         if (MemWriteM && mis) begin
            if (!m_err) m_erraddr <= a;
            m_err <= 1'b1;
         end
         m_edges <= m_edges + 32'd1;
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_rd_known) begin
         checks++;
         if (ReadData !== m_rd) begin
            errors++;
            $display("FAIL model_ReadData t=%0t actual=%h required=%h", $time, ReadData, m_rd);
         end
      end
      checks++;
      if (GpioOut !== m_gpio) begin
         errors++;
         $display("FAIL model_GpioOut t=%0t actual=%h required=%h", $time, GpioOut, m_gpio);
      end
      checks++;
      if (MisalignErr !== m_err) begin
         errors++;
         $display("FAIL model_MisalignErr t=%0t actual=%b required=%b", $time, MisalignErr, m_err);
      end
      checks++;
      if (ErrAddr !== m_erraddr) begin
         errors++;
         $display("FAIL model_ErrAddr t=%0t actual=%h required=%h", $time, ErrAddr, m_erraddr);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic [1:0] sz);
      ALUResultM  = a;
      WriteDataM  = d;
      MemWriteM   = we;
      ByteAccessM = sz;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("reset_ReadData", ReadData, 32'h0);
      chk("reset_GpioOut", GpioOut, 32'h0);
      chk("reset_MisalignErr", {31'h0, MisalignErr}, 32'h0);
      chk("reset_ErrAddr", ErrAddr, 32'h0);

      // Counter reads right after reset release: values 0,1,2.
      reset = 1'b0;
      step(CYC, 32'h0, 1'b0, SZ_W); chk("cycle_0", ReadData, 32'h0);
      step(CYC, 32'h0, 1'b0, SZ_W); chk("cycle_1", ReadData, 32'h1);
      step(CYC, 32'h0, 1'b0, SZ_W); chk("cycle_2", ReadData, 32'h2);

      step(32'h10, 32'h1122_3344, 1'b1, SZ_W);
      step(32'h12, 32'h0000_00AA, 1'b1, SZ_B);
      step(32'h10, 32'h0, 1'b0, SZ_W);
      chk("sb_merge", ReadData, 32'h11AA_3344);

      step(32'h20, 32'hDEAD_BEEF, 1'b1, SZ_W);
      chk("write_first", ReadData, 32'hDEAD_BEEF);

      step(MMIO, 32'h5A, 1'b1, SZ_W);
      chk("gpio_sw", GpioOut, 32'h5A);
      step(MMIO + 32'd1, 32'hFF, 1'b1, SZ_B);
      chk("gpio_sb", GpioOut, 32'hFF5A);
      chk("gpio_sb_read", ReadData, 32'hFF5A);

      step(32'h22, 32'h0000_CAFE, 1'b1, SZ_H);
      chk("sh_upper", ReadData, 32'hCAFE_BEEF);

      step(32'h8000_0000, 32'h1234_5678, 1'b1, SZ_W);
      chk("unmapped_noerr", {31'h0, MisalignErr}, 32'h0);
      step(32'h8000_0000, 32'h0, 1'b0, SZ_W);
      chk("unmapped_read", ReadData, 32'h0);
      step(CYC, 32'h1, 1'b1, SZ_W);
      chk("cycle_store_noerr", {31'h0, MisalignErr}, 32'h0);

      step(32'h0, 32'h0, 1'b1, SZ_W);
      step(32'h3, 32'hBEEF, 1'b1, SZ_H);
      chk("mis_flag", {31'h0, MisalignErr}, 32'h1);
      chk("mis_addr", ErrAddr, 32'h3);
      step(32'h0, 32'h0, 1'b0, SZ_W);
      chk("mis_nowrite", ReadData, 32'h0);
      step(32'h5, 32'h77, 1'b1, SZ_W);
      chk("mis_sticky_addr", ErrAddr, 32'h3);
      step(32'h11, 32'h0, 1'b0, SZ_W);
      chk("mis_load", ReadData, 32'h11AA_3344);

      for (int i = 0; i < 60; i++) begin
         step($urandom_range(0, 63), $urandom, 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)));
      end
      step(32'h10, 32'h1122_3344, 1'b1, SZ_W);

      // Reset during a store: store is blocked, RAM persists.
      ALUResultM = 32'h10; WriteDataM = 32'h9999_9999; MemWriteM = 1'b1; ByteAccessM = SZ_W;
      reset = 1'b1;
      #1;
      chk("async_reset_ReadData", ReadData, 32'h0);
      chk("async_reset_Err", {31'h0, MisalignErr}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("reset2_GpioOut", GpioOut, 32'h0);
      chk("reset2_ErrAddr", ErrAddr, 32'h0);
      reset = 1'b0;
      step(32'h10, 32'h0, 1'b0, SZ_W);
      chk("ram_persists", ReadData, 32'h1122_3344);

      // Counter wrap.
      force dut.r_cycle = 32'hFFFF_FFFE;
      m_adj = 32'hFFFF_FFFE - m_edges;
      #1;
      release dut.r_cycle;
      step(CYC, 32'h0, 1'b0, SZ_W); chk("wrap_fffe", ReadData, 32'hFFFF_FFFE);
      step(CYC, 32'h0, 1'b0, SZ_W); chk("wrap_ffff", ReadData, 32'hFFFF_FFFF);
      step(CYC, 32'h0, 1'b0, SZ_W); chk("wrap_zero", ReadData, 32'h0);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
